// File: rtl/hi_lo_if.sv
// hi_lo_if: operation and result bus between the issue stage and the HI/LO unit
// master drives the instruction and ALU operands; slave (the unit) returns
// read data, stall, busy and the architectural HI/LO values.
interface hi_lo_if;
  logic [5:0]  ALU_operation;
  logic        op_valid;
  logic [31:0] ALU_output;
  logic [31:0] ALU_HI_output;
  logic [31:0] ALU_LO_output;
  logic [31:0] divisor;
  logic [31:0] HI_LO_read_data;
  logic        stall;
  logic        busy;
  logic [31:0] HI_value;
  logic [31:0] LO_value;
  modport master (
    output ALU_operation, op_valid, ALU_output, ALU_HI_output, ALU_LO_output, divisor,
    input  HI_LO_read_data, stall, busy, HI_value, LO_value
  );
  modport slave (
    input  ALU_operation, op_valid, ALU_output, ALU_HI_output, ALU_LO_output, divisor,
    output HI_LO_read_data, stall, busy, HI_value, LO_value
  );
endinterface

// File: rtl/hi_lo_unit.sv
// hi_lo_unit: MIPS HI/LO register file with multi-cycle multiply/divide commit
// Ports: clk, reset (async, active-high), bus (hi_lo_if.slave: op/operands in,
// read data, stall, busy, HI/LO out). Parameters MULT_LATENCY, DIV_LATENCY (1..15).
// Optional macro HI_LO_BYPASS_EN: MFHI/MFLO in the final busy cycle read the
// pending result instead of stalling.
module hi_lo_unit #(
  parameter int MULT_LATENCY = 4,
  parameter int DIV_LATENCY  = 8
) (
  input logic     clk,
  input logic     reset,
  hi_lo_if.slave  bus
);
  typedef enum logic {IDLE, BUSY} state_t;
  localparam logic [5:0] MTHI = 6'b010001;
  localparam logic [5:0] MTLO = 6'b010011;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d, phi_q, phi_d, plo_q, plo_d;
  logic        disc_q, disc_d;
  logic        hilo_op, is_md, is_div, is_mf, last, byp, start, idle_op;
  logic [31:0] hi_src, lo_src;
  // 0100xx and 0110xx are the HI/LO class
  assign hilo_op = bus.ALU_operation[5:4] == 2'b01 && !bus.ALU_operation[2];
  assign is_md   = bus.ALU_operation[5:2] == 4'b0110;
  assign is_div  = is_md && bus.ALU_operation[1];
  assign is_mf   = bus.ALU_operation[5:2] == 4'b0100 && !bus.ALU_operation[0];
  assign last    = state_q == BUSY && cnt_q == 4'd0;
`ifdef HI_LO_BYPASS_EN
  assign byp = last && is_mf;
`else
  assign byp = 1'b0;
`endif
  assign idle_op = bus.op_valid && state_q == IDLE;
  assign start   = idle_op && is_md;
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  always_comb begin
    state_d = state_q == IDLE ? (start ? BUSY : IDLE) : (cnt_q == 4'd0 ? IDLE : BUSY);
  end
  always_comb begin
    cnt_d  = start ? (is_div ? 4'(DIV_LATENCY - 1) : 4'(MULT_LATENCY - 1))
                   : (state_q == BUSY && cnt_q != 4'd0 ? cnt_q - 4'd1 : cnt_q);
    phi_d  = start ? bus.ALU_HI_output : phi_q;
    plo_d  = start ? bus.ALU_LO_output : plo_q;
    disc_d = start ? (is_div && bus.divisor == 32'd0) : disc_q;
    hi_d   = last && !disc_q ? phi_q
           : (idle_op && bus.ALU_operation == MTHI ? bus.ALU_output : hi_q);
    lo_d   = last && !disc_q ? plo_q
           : (idle_op && bus.ALU_operation == MTLO ? bus.ALU_output : lo_q);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      phi_q  <= '0;
      plo_q  <= '0;
      disc_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      phi_q  <= phi_d;
      plo_q  <= plo_d;
      disc_q <= disc_d;
    end
  always_comb begin
    hi_src              = byp && !disc_q ? phi_q : hi_q;
    lo_src              = byp && !disc_q ? plo_q : lo_q;
    bus.busy            = state_q == BUSY;
    bus.stall           = bus.op_valid && state_q == BUSY && hilo_op && !byp;
    bus.HI_LO_read_data = is_mf ? (bus.ALU_operation[1] ? lo_src : hi_src) : 32'd0;
    bus.HI_value        = hi_q;
    bus.LO_value        = lo_q;
  end
endmodule
